// File: rtl/uart_port_master.sv
// Byte-stream to UART chip-port bridge: arbitrates reads/writes onto CSN/WEN/OEN strobes with holdoff.
// Optional receive-error counter (ERR_CNT/ERR_CLR) is built when UART_PORT_MASTER_ERRCNT_EN is defined.
//
// state | meaning
// IDLE  | waiting; read (RXRDY, RX slot empty) wins over write (TXRDY, TX_VALID)
// WR    | one-cycle write strobe, UART_DIN driven
// RD    | one-cycle read strobe, UART_DOUT/status captured on exit
// HOLD  | HOLDOFF quiet cycles before the UART status is trusted again
module uart_port_master #(
    parameter int unsigned HOLDOFF = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic [2:0] RX_STATUS,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       CSN,
    output logic       WEN,
    output logic       OEN,
    output logic [7:0] UART_DIN,
    input  logic [7:0] UART_DOUT,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    input  logic       OVERFLOW,
    output logic       BUSY
`ifdef UART_PORT_MASTER_ERRCNT_EN
    ,
    output logic [7:0] ERR_CNT,
    input  logic       ERR_CLR
`endif
);

    generate
        if (HOLDOFF < 1 || HOLDOFF > 15) begin : g_bad_holdoff
            $error("uart_port_master: HOLDOFF must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

    state_t     state;
    logic [3:0] hold_cnt;
    logic       read_req;
    logic [2:0] uart_status;

    // A pending RX byte blocks further reads so it is never overwritten.
    assign read_req    = RXRDY && !RX_VALID;
    assign uart_status = {OVERFLOW, FRAMING_ERR, PARITY_ERR};
    assign TX_READY    = !RESET && (state == IDLE) && !read_req && TXRDY;
    assign BUSY        = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            hold_cnt  <= 4'd0;
            CSN       <= 1'b1;
            WEN       <= 1'b1;
            OEN       <= 1'b1;
            UART_DIN  <= 8'd0;
            RX_DATA   <= 8'd0;
            RX_STATUS <= 3'd0;
            RX_VALID  <= 1'b0;
        end else begin
            if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (read_req) begin
                        state <= RD;
                        CSN   <= 1'b0;
                        OEN   <= 1'b0;
                    end else if (TX_VALID && TX_READY) begin
                        state    <= WR;
                        UART_DIN <= TX_DATA;
                        CSN      <= 1'b0;
                        WEN      <= 1'b0;
                    end
                end
                WR: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                    CSN      <= 1'b1;
                    WEN      <= 1'b1;
                end
                RD: begin
                    state     <= HOLD;
                    hold_cnt  <= HOLD_INIT;
                    CSN       <= 1'b1;
                    OEN       <= 1'b1;
                    RX_DATA   <= UART_DOUT;
                    RX_STATUS <= uart_status;
                    RX_VALID  <= 1'b1;
                end
                HOLD: begin
                    if (hold_cnt <= 4'd1) begin
                        state    <= IDLE;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    CSN   <= 1'b1;
                    WEN   <= 1'b1;
                    OEN   <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_PORT_MASTER_ERRCNT_EN
    // Counts captured bytes carrying any error flag; clear beats increment.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ERR_CNT <= 8'd0;
        end else if (ERR_CLR) begin
            ERR_CNT <= 8'd0;
        end else if ((state == RD) && (uart_status != 3'd0) && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_port_master.sv
// Self-checking bench for uart_port_master: directed scenarios plus randomized traffic against a queue model.
// Error-counter scenario runs only when UART_PORT_MASTER_ERRCNT_EN is defined.
module tb_uart_port_master;

    localparam int HOLDOFF = 3;

    logic       CLK;
    logic       RESET;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic [2:0] RX_STATUS;
    logic       RX_VALID;
    logic       RX_READY;
    logic       CSN;
    logic       WEN;
    logic       OEN;
    logic [7:0] UART_DIN;
    logic [7:0] UART_DOUT;
    logic       TXRDY;
    logic       RXRDY;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;
    logic       BUSY;
`ifdef UART_PORT_MASTER_ERRCNT_EN
    logic [7:0] ERR_CNT;
    logic       ERR_CLR;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int n_wr = 0;
    int n_rd = 0;
    int last_wr = 0;
    int last_rd = 0;
    logic [7:0] last_din = 8'd0;

    uart_port_master #(.HOLDOFF(HOLDOFF)) dut (
        .CLK(CLK), .RESET(RESET),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_STATUS(RX_STATUS), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .CSN(CSN), .WEN(WEN), .OEN(OEN), .UART_DIN(UART_DIN), .UART_DOUT(UART_DOUT),
        .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR),
        .OVERFLOW(OVERFLOW), .BUSY(BUSY)
`ifdef UART_PORT_MASTER_ERRCNT_EN
        , .ERR_CNT(ERR_CNT), .ERR_CLR(ERR_CLR)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic idle_inputs();
        TX_DATA     = 8'd0;
        TX_VALID    = 1'b0;
        RX_READY    = 1'b0;
        UART_DOUT   = 8'd0;
        TXRDY       = 1'b0;
        RXRDY       = 1'b0;
        PARITY_ERR  = 1'b0;
        FRAMING_ERR = 1'b0;
        OVERFLOW    = 1'b0;
`ifdef UART_PORT_MASTER_ERRCNT_EN
        ERR_CLR     = 1'b0;
`endif
    endtask

    // Advance to the next falling edge and log any strobe visible in that cycle.
    task automatic cyc();
        @(negedge CLK);
        cyc_n++;
        if (!CSN && !WEN) begin
            n_wr++;
            last_wr  = cyc_n;
            last_din = UART_DIN;
        end
        if (!CSN && !OEN) begin
            n_rd++;
            last_rd = cyc_n;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && BUSY; i++) cyc();
        n_vec++;
        if (BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: BUSY=%b required 0", BUSY);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        TXRDY = 1'b1; RXRDY = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hFF; UART_DOUT = 8'h77;
        cyc(); cyc(); #1;
        n_vec++; if ({CSN, WEN, OEN} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes: %b required 111", {CSN, WEN, OEN}); end
        n_vec++; if (UART_DIN !== 8'd0) begin n_bad++; $display("FAIL rst_din: %h required 00", UART_DIN); end
        n_vec++; if ({RX_DATA, RX_STATUS, RX_VALID} !== 12'd0) begin n_bad++; $display("FAIL rst_rx: %h/%b/%b required 0", RX_DATA, RX_STATUS, RX_VALID); end
        n_vec++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: %b required 0", BUSY); end
        n_vec++; if (TX_READY !== 1'b0) begin n_bad++; $display("FAIL rst_tx_ready: %b required 0", TX_READY); end
        idle_inputs();
        RESET = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int busy_n = 0;
        int rdy_n = 0;
        int wr0;
        idle_inputs();
        TXRDY = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hA5; #1;
        n_vec++; if (TX_READY !== 1'b1) begin n_bad++; $display("FAIL wr_tx_ready: %b required 1", TX_READY); end
        cyc();
        TX_VALID = 1'b0; #1;
        n_vec++; if ({CSN, WEN, OEN} !== 3'b001) begin n_bad++; $display("FAIL wr_strobe: %b required 001", {CSN, WEN, OEN}); end
        n_vec++; if (UART_DIN !== 8'hA5) begin n_bad++; $display("FAIL wr_din: %h required a5", UART_DIN); end
        wr0 = n_wr;
        for (int i = 0; i < 10; i++) begin
            if (BUSY) busy_n++;
            if (BUSY && TX_READY) rdy_n++;
            cyc(); #1;
        end
        n_vec++; if (busy_n != 4) begin n_bad++; $display("FAIL wr_busy_len: %0d required 4", busy_n); end
        n_vec++; if (n_wr != wr0) begin n_bad++; $display("FAIL wr_single: %0d extra strobes required 0", n_wr - wr0); end
        n_vec++; if (rdy_n != 0) begin n_bad++; $display("FAIL wr_ready_busy: %0d required 0", rdy_n); end
    endtask

    task automatic test_read();
        int rd0;
        idle_inputs();
        RXRDY = 1'b1; UART_DOUT = 8'h3C; PARITY_ERR = 1'b1; TXRDY = 1'b1; #1;
        n_vec++; if (TX_READY !== 1'b0) begin n_bad++; $display("FAIL rd_tx_ready: %b required 0", TX_READY); end
        rd0 = n_rd;
        cyc(); #1;
        n_vec++; if ({CSN, WEN, OEN} !== 3'b010) begin n_bad++; $display("FAIL rd_strobe: %b required 010", {CSN, WEN, OEN}); end
        cyc(); #1;
        n_vec++; if (RX_VALID !== 1'b1) begin n_bad++; $display("FAIL rd_valid: %b required 1", RX_VALID); end
        n_vec++; if (RX_DATA !== 8'h3C) begin n_bad++; $display("FAIL rd_data: %h required 3c", RX_DATA); end
        n_vec++; if (RX_STATUS !== 3'b001) begin n_bad++; $display("FAIL rd_status: %b required 001", RX_STATUS); end
        UART_DOUT = 8'hC3; PARITY_ERR = 1'b0; OVERFLOW = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        #1;
        n_vec++; if (n_rd != rd0 + 1) begin n_bad++; $display("FAIL rd_once: %0d strobes required 1", n_rd - rd0); end
        n_vec++; if ({RX_DATA, RX_STATUS} !== {8'h3C, 3'b001}) begin n_bad++; $display("FAIL rd_hold: %h/%b required 3c/001", RX_DATA, RX_STATUS); end
        RX_READY = 1'b1;
        cyc();
        RX_READY = 1'b0; RXRDY = 1'b0; #1;
        n_vec++; if (RX_VALID !== 1'b0) begin n_bad++; $display("FAIL rd_consume: %b required 0", RX_VALID); end
        n_vec++; if (n_rd != rd0 + 1) begin n_bad++; $display("FAIL rd_no_rearm: %0d strobes required 1", n_rd - rd0); end
        idle_inputs();
    endtask

    task automatic test_priority();
        int rd0, wr0, bad_rdy;
        logic acc_pend;
        idle_inputs();
        wait_idle();
        RX_READY = 1'b1; RXRDY = 1'b1; TXRDY = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'h5A; #1;
        n_vec++; if (TX_READY !== 1'b0) begin n_bad++; $display("FAIL pri_tx_ready: %b required 0", TX_READY); end
        rd0 = n_rd; wr0 = n_wr; bad_rdy = 0; acc_pend = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (n_rd > rd0) RXRDY = 1'b0;
            if (acc_pend) begin TX_VALID = 1'b0; acc_pend = 1'b0; end
            #1;
            if (BUSY && TX_READY) bad_rdy++;
            if (TX_VALID && TX_READY) acc_pend = 1'b1;
        end
        n_vec++; if (n_rd != rd0 + 1 || n_wr != wr0 + 1) begin n_bad++; $display("FAIL pri_counts: rd %0d wr %0d required 1 1", n_rd - rd0, n_wr - wr0); end
        n_vec++; if (last_wr - last_rd != 5) begin n_bad++; $display("FAIL pri_spacing: %0d required 5", last_wr - last_rd); end
        n_vec++; if (last_din !== 8'h5A) begin n_bad++; $display("FAIL pri_din: %h required 5a", last_din); end
        n_vec++; if (bad_rdy != 0) begin n_bad++; $display("FAIL pri_ready_busy: %0d required 0", bad_rdy); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int rd0, wr0, idx;
        logic [7:0] seq [2];
        logic [7:0] got [2];
        seq[0] = 8'h11; seq[1] = 8'h22;
        idle_inputs();
        wait_idle();
        RXRDY = 1'b1; UART_DOUT = 8'h81; TXRDY = 1'b1;
        rd0 = n_rd; wr0 = n_wr; idx = 0;
        got[0] = 8'h00; got[1] = 8'h00;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!CSN && !WEN && n_wr - wr0 <= 2) got[n_wr - wr0 - 1] = UART_DIN;
            if (n_rd > rd0 && OEN) UART_DOUT = 8'($urandom);
            TX_VALID = (idx < 2);
            TX_DATA  = seq[idx % 2];
            #1;
            if (TX_VALID && TX_READY) idx++;
        end
        TX_VALID = 1'b0;
        n_vec++; if (n_rd != rd0 + 1) begin n_bad++; $display("FAIL bp_one_read: %0d required 1", n_rd - rd0); end
        n_vec++; if (n_wr != wr0 + 2 || got[0] !== 8'h11 || got[1] !== 8'h22) begin n_bad++; $display("FAIL bp_writes: n=%0d %h %h required 2 11 22", n_wr - wr0, got[0], got[1]); end
        n_vec++; if (RX_VALID !== 1'b1 || RX_DATA !== 8'h81) begin n_bad++; $display("FAIL bp_hold: %b/%h required 1/81", RX_VALID, RX_DATA); end
        UART_DOUT = 8'h42; RX_READY = 1'b1;
        cyc();
        RX_READY = 1'b0;
        for (int i = 0; i < 10 && n_rd < rd0 + 2; i++) cyc();
        cyc(); #1;
        n_vec++; if (n_rd != rd0 + 2) begin n_bad++; $display("FAIL bp_second_read: %0d required 2", n_rd - rd0); end
        n_vec++; if (RX_VALID !== 1'b1 || RX_DATA !== 8'h42) begin n_bad++; $display("FAIL bp_second_data: %b/%h required 1/42", RX_VALID, RX_DATA); end
        RXRDY = 1'b0; RX_READY = 1'b1;
        wait_idle();
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mid_wr();
        int wr0;
        idle_inputs();
        wait_idle();
        TXRDY = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hC7;
        cyc();
        TX_VALID = 1'b0; #1;
        n_vec++; if ({CSN, WEN} !== 2'b00) begin n_bad++; $display("FAIL rwr_in_wr: %b required 00", {CSN, WEN}); end
        wr0 = n_wr;
        RESET = 1'b1;
        cyc(); #1;
        n_vec++; if ({CSN, WEN, OEN, BUSY} !== 4'b1110) begin n_bad++; $display("FAIL rwr_abort: %b required 1110", {CSN, WEN, OEN, BUSY}); end
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        n_vec++; if (n_wr != wr0) begin n_bad++; $display("FAIL rwr_replay: %0d extra strobes required 0", n_wr - wr0); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0]  txq [$];
        logic [10:0] rxq [$];
        logic [7:0]  exp_b;
        logic [10:0] exp_r;
        logic        tx_acc, rd_now, drain, prev_rxrdy, prev_rxvalid;
        int          last_any;
        idle_inputs();
        RX_READY = 1'b1;
        wait_idle();
        cyc();
        tx_acc = 1'b0; last_any = -100; prev_rxrdy = 1'b0; prev_rxvalid = 1'b0;
        for (int i = 0; i < 430; i++) begin
            drain = (i >= 400);
            cyc();
            n_vec++;
            if ((!WEN && !OEN) || (CSN != (WEN && OEN))) begin
                n_bad++; $display("FAIL rnd_strobe_rule: csn/wen/oen=%b%b%b", CSN, WEN, OEN);
            end
            rd_now = !CSN && !OEN;
            if (!CSN && (!WEN || !OEN)) begin
                n_vec++;
                if (cyc_n - last_any < HOLDOFF + 2) begin n_bad++; $display("FAIL rnd_gap: %0d required >= %0d", cyc_n - last_any, HOLDOFF + 2); end
                last_any = cyc_n;
            end
            if (!CSN && !WEN) begin
                exp_b = (txq.size() > 0) ? txq.pop_front() : 8'hxx;
                n_vec++;
                if (UART_DIN !== exp_b) begin n_bad++; $display("FAIL rnd_write: %h required %h", UART_DIN, exp_b); end
            end
            if (rd_now) begin
                rxq.push_back({UART_DOUT, OVERFLOW, FRAMING_ERR, PARITY_ERR});
                n_vec++;
                if (!(prev_rxrdy && !prev_rxvalid)) begin n_bad++; $display("FAIL rnd_read_cause: rxrdy=%b rx_valid=%b required 1 0", prev_rxrdy, prev_rxvalid); end
            end else begin
                UART_DOUT   = 8'($urandom);
                OVERFLOW    = ($urandom_range(0, 3) == 0);
                FRAMING_ERR = ($urandom_range(0, 3) == 0);
                PARITY_ERR  = ($urandom_range(0, 3) == 0);
            end
            prev_rxvalid = RX_VALID;
            TXRDY = ($urandom_range(0, 3) != 0);
            if (drain) begin
                TX_VALID = 1'b0; RXRDY = 1'b0; RX_READY = 1'b1;
            end else begin
                RXRDY    = ($urandom_range(0, 2) == 0);
                RX_READY = ($urandom_range(0, 1) == 1);
                if (tx_acc || !TX_VALID) begin
                    TX_VALID = ($urandom_range(0, 1) == 1);
                    TX_DATA  = 8'($urandom);
                end
            end
            prev_rxrdy = RXRDY;
            #1;
            tx_acc = TX_VALID && TX_READY;
            if (tx_acc) txq.push_back(TX_DATA);
            if (RX_VALID && RX_READY) begin
                exp_r = (rxq.size() > 0) ? rxq.pop_front() : 11'hxxx;
                n_vec++;
                if ({RX_DATA, RX_STATUS} !== exp_r) begin n_bad++; $display("FAIL rnd_read: %h/%b required %h/%b", RX_DATA, RX_STATUS, exp_r[10:3], exp_r[2:0]); end
            end
        end
        n_vec++;
        if (txq.size() != 0 || rxq.size() != 0) begin n_bad++; $display("FAIL rnd_drain: tx %0d rx %0d left required 0 0", txq.size(), rxq.size()); end
        idle_inputs();
    endtask

`ifdef UART_PORT_MASTER_ERRCNT_EN
    task automatic test_errcnt();
        int rd0;
        idle_inputs();
        RX_READY = 1'b1;
        wait_idle();
        ERR_CLR = 1'b1;
        cyc();
        ERR_CLR = 1'b0; #1;
        n_vec++; if (ERR_CNT !== 8'd0) begin n_bad++; $display("FAIL ec_start: %0d required 0", ERR_CNT); end
        FRAMING_ERR = 1'b1; RXRDY = 1'b1; UART_DOUT = 8'h00;
        rd0 = n_rd;
        for (int i = 0; i < 200 && n_rd < rd0 + 10; i++) cyc();
        cyc(); #1;
        n_vec++; if (ERR_CNT !== 8'd10) begin n_bad++; $display("FAIL ec_ten: %0d required 10", ERR_CNT); end
        for (int i = 0; i < 3000 && n_rd < rd0 + 300; i++) cyc();
        RXRDY = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        #1;
        n_vec++; if (n_rd != rd0 + 300) begin n_bad++; $display("FAIL ec_reads: %0d required 300", n_rd - rd0); end
        n_vec++; if (ERR_CNT !== 8'd255) begin n_bad++; $display("FAIL ec_saturate: %0d required 255", ERR_CNT); end
        ERR_CLR = 1'b1;
        cyc();
        ERR_CLR = 1'b0; #1;
        n_vec++; if (ERR_CNT !== 8'd0) begin n_bad++; $display("FAIL ec_clear: %0d required 0", ERR_CNT); end
        rd0 = n_rd;
        ERR_CLR = 1'b1; RXRDY = 1'b1;
        for (int i = 0; i < 10 && n_rd < rd0 + 1; i++) cyc();
        RXRDY = 1'b0;
        cyc(); #1;
        n_vec++; if (n_rd != rd0 + 1 || ERR_CNT !== 8'd0) begin n_bad++; $display("FAIL ec_clear_wins: reads %0d cnt %0d required 1 0", n_rd - rd0, ERR_CNT); end
        ERR_CLR = 1'b0;
        wait_idle();
        idle_inputs();
    endtask
`endif

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_backpressure();
        test_reset_mid_wr();
        test_random();
`ifdef UART_PORT_MASTER_ERRCNT_EN
        test_errcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_port_master.md
UART_PORT_MASTER -- requirements
Module: uart_port_master

Interface
REQ-001 SHALL have parameter HOLDOFF, default 3, range 1..15: idle cycles after each UART strobe before RXRDY/TXRDY are sampled again.
REQ-002 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port TX_DATA  input  8  byte to transmit.
REQ-005 SHALL have port TX_VALID  input  1  TX_DATA is valid.
REQ-006 SHALL have port TX_READY  output  1  byte accepted this cycle when high with TX_VALID.
REQ-007 SHALL have port RX_DATA  output  8  received byte.
REQ-008 SHALL have port RX_STATUS  output  3  {OVERFLOW, FRAMING_ERR, PARITY_ERR} captured with RX_DATA.
REQ-009 SHALL have port RX_VALID  output  1  RX_DATA/RX_STATUS valid.
REQ-010 SHALL have port RX_READY  input  1  downstream accepts RX_DATA.
REQ-011 SHALL have ports CSN, WEN, OEN  output  1 each  active-low UART chip-select, write and read strobes.
REQ-012 SHALL have port UART_DIN  output  8  byte driven to the UART DATA_IN.
REQ-013 SHALL have port UART_DOUT  input  8  UART DATA_OUT.
REQ-014 SHALL have ports TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW  input  1 each  UART status.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, WR, RD and HOLD, with the state register and CSN/WEN/OEN/UART_DIN all registered.
REQ-017 In IDLE, SHALL go to RD when RXRDY=1 and RX_VALID=0; read has priority over write.
REQ-018 Otherwise in IDLE, SHALL drive TX_READY=1 (combinational) when TXRDY=1; on TX_VALID&TX_READY, SHALL load UART_DIN<=TX_DATA and go to WR.
REQ-019 SHALL hold TX_READY=0 in every state except IDLE and whenever a read is chosen.
REQ-020 In WR, SHALL hold CSN=0, WEN=0, OEN=1 for exactly one cycle, then go to HOLD.
REQ-021 In RD, SHALL hold CSN=0, OEN=0, WEN=1 for exactly one cycle.
REQ-022 On the clock edge leaving RD, SHALL capture RX_DATA<=UART_DOUT and RX_STATUS<={OVERFLOW,FRAMING_ERR,PARITY_ERR} and set RX_VALID=1, then go to HOLD.
REQ-023 In HOLD, SHALL keep CSN=WEN=OEN=1 for exactly HOLDOFF cycles (4-bit down-counter), then return to IDLE.
REQ-024 With HOLDOFF=3, SHALL make the write-to-write strobe spacing exactly 5 cycles (WR 1 + HOLD 3 + IDLE 1).
REQ-025 SHALL clear RX_VALID on RX_VALID&RX_READY.
REQ-026 SHALL hold RX_DATA and RX_STATUS stable while RX_VALID=1 and RX_READY=0.
REQ-027 SHALL NOT start a read while RX_VALID=1; writes continue meanwhile.
REQ-028 SHALL never drive WEN=0 and OEN=0 in the same cycle, and SHALL drive CSN=0 only in WR or RD.
REQ-029 When a write is accepted and the RX register is consumed in the same cycle, SHALL perform both actions.

Reset
REQ-030 While RESET=1 at a clock edge, SHALL force state=IDLE, CSN=WEN=OEN=1, UART_DIN=0, RX_DATA=0, RX_STATUS=0, RX_VALID=0, BUSY=0, holdoff counter=0 and (if present) ERR_CNT=0.
REQ-031 SHALL drive TX_READY=0 during reset.
REQ-032 Reset asserted mid-WR or mid-RD SHALL abort the strobe on the next edge; the byte is lost and is not replayed.

Configuration
REQ-033 With macro UART_PORT_MASTER_ERRCNT_EN defined, SHALL add output ERR_CNT (8 bits) and input ERR_CLR (1 bit).
REQ-034 With the macro defined, SHALL increment ERR_CNT on each RD exit whose captured RX_STATUS is nonzero, saturating at 255.
REQ-035 With the macro defined, ERR_CLR=1 SHALL zero ERR_CNT; when both occur in the same cycle, clear wins.
REQ-036 Without the macro, SHALL omit both ports and the counter logic; all other behaviour is identical.

Verification
REQ-037 Bench SHALL cover: TXRDY=1, TX_VALID with 0xA5 -> TX_READY high 1 cycle; next cycle CSN=WEN=0 for 1 cycle with UART_DIN=0xA5; BUSY high 4 cycles.
REQ-038 Bench SHALL cover: RXRDY=1, UART_DOUT=0x3C, PARITY_ERR=1 -> one OEN/CSN strobe; RX_VALID=1, RX_DATA=0x3C, RX_STATUS=3'b001.
REQ-039 Bench SHALL cover: RXRDY=1 and TX_VALID=1 simultaneously -> RD first; TX_READY=0 until IDLE returns; write strobe 5 cycles after read strobe.
REQ-040 Bench SHALL cover: RX_READY=0 with RXRDY held high -> exactly one read strobe; writes of 0x11, 0x22 still complete; second read only after RX_READY pulse.
REQ-041 Bench SHALL cover: RESET=1 in the WR cycle -> next edge CSN=WEN=OEN=1, BUSY=0; no second write strobe.
REQ-042 Bench SHALL cover: with UART_PORT_MASTER_ERRCNT_EN, 300 reads with FRAMING_ERR=1 -> ERR_CNT=255; ERR_CLR pulse -> 0.
